// File: rtl/alu_result_stage.sv
// Registered ALU result stage with a 2-entry skid buffer and capture-time flags.
// Optional parity output enabled by defining ALU_RESULT_STAGE_PARITY_EN.
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
`ifdef ALU_RESULT_STAGE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_carry
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic             parity;
`endif
    logic             carry;
  } entry_t;

  logic [1:0] state_q;
  logic [1:0] state_n;
  logic       in_ready_q;
  entry_t     m_q;
  entry_t     s_q;
  entry_t     in_entry;
  logic       in_fire;
  logic       out_fire;
  logic       load_m_in;
  logic       load_m_s;
  logic       load_s;

  // Flags come from the live input so stored data never feeds them.
  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result;
    in_entry.zero   = ~|in_result;
    in_entry.neg    = in_result[WIDTH-1];
`ifdef ALU_RESULT_STAGE_PARITY_EN
    in_entry.parity = ^in_result;
`endif
    in_entry.carry  = in_carry;
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_n   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_m_in = 1'b1;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_m_in = 1'b1;
        end else if (in_fire) begin
          load_s  = 1'b1;
          state_n = FULL;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_m_s = 1'b1;
          state_n  = BUSY;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n   = EMPTY;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_n;
      in_ready_q <= (state_n != FULL);
      if (load_m_in) m_q <= in_entry;
      else if (load_m_s) m_q <= s_q;
      if (load_s) s_q <= in_entry;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = m_q.result;
  assign out_zero   = m_q.zero;
  assign out_neg    = m_q.neg;
  assign out_carry  = m_q.carry;
`ifdef ALU_RESULT_STAGE_PARITY_EN
  assign out_parity = m_q.parity;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a 2-deep queue model.
// Directed literal checks pin the model; parity checked when macro defined.
module tb_alu_result_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_result = '0;
  logic         in_carry = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_neg;
  logic         out_carry;
`ifdef ALU_RESULT_STAGE_PARITY_EN
  logic         out_parity;
`endif

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
`ifdef ALU_RESULT_STAGE_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_carry  (out_carry)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         p;
    logic         c;
  } ent_t;

  function automatic ent_t mk(logic [W-1:0] r, logic c);
    ent_t e;
    e.r = r;
    e.z = (r == 0);
    e.n = ((r >> (W - 1)) & 1) != 0;
    e.p = ($countones(r) % 2) == 1;
    e.c = c;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  ent_t mq0 = '0;
  ent_t mq1 = '0;
  int   mcnt = 0;
  ent_t mdisp = '0;
  logic m_in_ready = 1'b1;
  logic live = 1'b0;

  // Model: bounded FIFO of 2; display holds last head until reset.
  always @(posedge clk) begin
    ent_t t0, t1, d;
    int   n;
    logic inf, outf;
    t0 = mq0;
    t1 = mq1;
    n  = mcnt;
    d  = mdisp;
    if (rst) begin
      n = 0;
      d = '0;
    end else if (flush) begin
      n = 0;
    end else begin
      inf  = in_valid && m_in_ready;
      outf = (n != 0) && out_ready;
      if (outf) begin
        t0 = t1;
        n  = n - 1;
      end
      if (inf) begin
        if (n == 0) t0 = mk(in_result, in_carry);
        else t1 = mk(in_result, in_carry);
        n = n + 1;
      end
      if (n != 0) d = t0;
    end
    mq0        <= t0;
    mq1        <= t1;
    mcnt       <= n;
    mdisp      <= d;
    m_in_ready <= (n != 2);
    if (rst) live <= 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      chk("in_ready", 32'(in_ready), 32'(m_in_ready));
      chk("out_result", 32'(out_result), 32'(mdisp.r));
      chk("out_zero", 32'(out_zero), 32'(mdisp.z));
      chk("out_neg", 32'(out_neg), 32'(mdisp.n));
      chk("out_carry", 32'(out_carry), 32'(mdisp.c));
`ifdef ALU_RESULT_STAGE_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(mdisp.p));
`endif
    end
  end

  task automatic drive(logic v, logic [W-1:0] r, logic c,
                       logic ordy, logic fl, logic rs);
    in_valid  = v;
    in_result = r;
    in_carry  = c;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0, 1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(out_result), 32'd0);

    drive(1, 8'h00, 1, 1, 0, 0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", 32'(out_result), 32'h00);
    chk("t1_zero", 32'(out_zero), 32'd1);
    chk("t1_neg", 32'(out_neg), 32'd0);
    chk("t1_carry", 32'(out_carry), 32'd1);
    drive(0, 8'h00, 0, 1, 0, 0);
    chk("t1_drain", 32'(out_valid), 32'd0);

    drive(1, 8'hA5, 0, 0, 0, 0);
    drive(1, 8'h3C, 0, 0, 0, 0);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_result", 32'(out_result), 32'hA5);
    chk("bp_neg", 32'(out_neg), 32'd1);
    drive(0, 8'h00, 0, 1, 0, 0);
    chk("bp_second", 32'(out_result), 32'h3C);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    drive(0, 8'h00, 0, 1, 0, 0);
    chk("bp_empty", 32'(out_valid), 32'd0);

    for (int i = 1; i <= 16; i++) begin
      drive(1, W'(i), 0, 1, 0, 0);
      chk("stream_ready", 32'(in_ready), 32'd1);
      chk("stream_result", 32'(out_result), 32'(i));
    end
    drive(0, 8'h00, 0, 1, 0, 0);

    drive(1, 8'h11, 0, 0, 0, 0);
    drive(1, 8'h22, 0, 0, 0, 0);
    drive(1, 8'h33, 0, 0, 1, 0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    drive(0, 8'h00, 0, 1, 0, 0);
    chk("fl_stay", 32'(out_valid), 32'd0);

    drive(1, 8'h44, 1, 0, 0, 0);
    drive(1, 8'h55, 1, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0, 1);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_result", 32'(out_result), 32'd0);
    chk("mr_flags", 32'({out_zero, out_neg, out_carry}), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    drive(1, 8'h80, 0, 1, 0, 0);
    chk("mr_neg", 32'(out_neg), 32'd1);
    chk("mr_zero", 32'(out_zero), 32'd0);
    drive(0, 8'h00, 0, 1, 0, 0);

`ifdef ALU_RESULT_STAGE_PARITY_EN
    drive(1, 8'h07, 0, 0, 0, 0);
    chk("par_07", 32'(out_parity), 32'd1);
    drive(1, 8'h03, 0, 1, 0, 0);
    chk("par_03", 32'(out_parity), 32'd0);
    drive(0, 8'h00, 0, 1, 0, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7),
            W'($urandom),
            1'($urandom),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 199) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
